// File: rtl/rr_grant_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// Holds the state encoding, requester-count derivation and rotate-priority select.
package rr_grant_sched_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } state_e;

  function automatic int num_req(input int idx_width);
    return 1 << idx_width;
  endfunction

  // First set bit of req searching ptr, ptr+1, ... modulo n; n is a power of two.
  function automatic logic [31:0] rr_select(
    input logic [31:0] req,
    input int unsigned ptr,
    input int unsigned n
  );
    logic [31:0] sel;
    logic        found;
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (!found && req[idx[4:0]]) begin
          sel[idx[4:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_onehot_to_bin.sv
// One-hot to binary encoder for the grant index.
// All-zero input encodes to index 0.
import rr_grant_sched_pkg::*;

module rr_onehot_to_bin #(
  parameter  int IDX_WIDTH = 2,
  localparam int NUM_REQ   = num_req(IDX_WIDTH)
) (
  input  logic [NUM_REQ-1:0]   onehot,
  output logic [IDX_WIDTH-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin scheduler with bounded tenure, registered one-hot grant
// and binary grant index for a downstream mux select.
import rr_grant_sched_pkg::*;

module rr_grant_sched #(
  parameter  int IDX_WIDTH  = 2,
  parameter  int HOLD_WIDTH = 4,
  parameter  int MAX_HOLD   = 4,
  localparam int NUM_REQ    = num_req(IDX_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
    HOLD_WIDTH'(MAX_HOLD - 1);

  state_e                state;
  state_e                state_n;
  logic [IDX_WIDTH-1:0]  ptr;
  logic [IDX_WIDTH-1:0]  ptr_n;
  logic [IDX_WIDTH-1:0]  owner;
  logic [IDX_WIDTH-1:0]  owner_n;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [HOLD_WIDTH-1:0] hold_n;
  logic [NUM_REQ-1:0]    grant_n;
  logic [IDX_WIDTH-1:0]  grant_idx_n;
  logic [NUM_REQ-1:0]    sel_oh;
  logic [NUM_REQ-1:0]    owner_oh;
  logic                  others;
  logic                  take_new;

  assign sel_oh = NUM_REQ'(rr_select(32'(req), 32'(ptr), NUM_REQ));

  assign owner_oh = NUM_REQ'(1) << owner;
  assign others   = |(req & ~owner_oh);

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    grant_n  = grant;
    take_new = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && |req) begin
          grant_n  = sel_oh;
          hold_n   = '0;
          take_new = 1'b1;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        hold_n = hold_cnt + 1'b1;
        if (!enable) begin
          grant_n = '0;
          hold_n  = '0;
          state_n = IDLE;
        end else if (!req[owner]) begin
          // Release wins over hold expiry; a newcomer is eligible here.
          if (|req) begin
            grant_n  = sel_oh;
            hold_n   = '0;
            take_new = 1'b1;
          end else begin
            grant_n = '0;
            hold_n  = '0;
            state_n = IDLE;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          hold_n = '0;
          if (others) begin
            grant_n  = sel_oh;
            take_new = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  rr_onehot_to_bin #(
    .IDX_WIDTH(IDX_WIDTH)
  ) u_enc (
    .onehot(grant_n),
    .idx   (grant_idx_n)
  );

  always_comb begin
    owner_n = owner;
    ptr_n   = ptr;
    if (take_new) begin
      owner_n = grant_idx_n;
      ptr_n   = grant_idx_n + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      owner       <= owner_n;
      hold_cnt    <= hold_n;
      grant       <= grant_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= |grant_n;
    end
  end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Self-checking bench for rr_grant_sched: directed tests plus a
// tenure-length reference model compared every cycle.
module tb_rr_grant_sched;

  localparam int IW = 2;
  localparam int NR = 4;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  int m_own = -1;
  int m_ptr = 0;
  int m_len = 0;

  typedef struct {
    bit          en;
    bit [NR-1:0] r;
    int          n;
  } vec_t;

  vec_t tbl [12] = '{
    '{1'b1, 4'b1111, 10}, '{1'b1, 4'b0110, 7},
    '{1'b1, 4'b0100, 3},  '{1'b1, 4'b1001, 9},
    '{1'b0, 4'b1001, 2},  '{1'b1, 4'b1011, 6},
    '{1'b1, 4'b0000, 2},  '{1'b1, 4'b0001, 1},
    '{1'b1, 4'b1110, 5},  '{1'b1, 4'b0101, 12},
    '{1'b1, 4'b0100, 4},  '{1'b1, 4'b1100, 9}
  };

  rr_grant_sched #(
    .IDX_WIDTH (IW),
    .HOLD_WIDTH(4),
    .MAX_HOLD  (MH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [NR-1:0] r, int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  // Model: owner id (-1 none) and how many cycles it has held so far.
  always @(posedge clk or negedge rst_n) begin : model
    int o, p, l;
    if (!rst_n) begin
      m_own <= -1;
      m_ptr <= 0;
      m_len <= 0;
    end else begin
      o = m_own;
      p = m_ptr;
      l = m_len;
      if (o < 0) begin
        if (enable && req != 0) begin
          o = pick(req, p); p = (o + 1) % NR; l = 1;
        end
      end else if (!enable) begin
        o = -1; l = 0;
      end else if (!req[o]) begin
        if (req != 0) begin
          o = pick(req, p); p = (o + 1) % NR; l = 1;
        end else begin
          o = -1; l = 0;
        end
      end else if (l >= MH) begin
        if ((req & ~(NR'(1) << o)) != 0) begin
          o = pick(req, p); p = (o + 1) % NR; l = 1;
        end else begin
          l = 1;
        end
      end else begin
        l = l + 1;
      end
      m_own <= o;
      m_ptr <= p;
      m_len <= l;
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("model_grant", int'(grant),
            (m_own < 0) ? 0 : (1 << m_own));
      check("model_idx", int'(grant_idx),
            (m_own < 0) ? 0 : m_own);
      check("model_valid", int'(grant_valid),
            (m_own < 0) ? 0 : 1);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_sync();
    rst_n  = 1'b0;
    req    = '0;
    enable = 1'b1;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic expect_out(string name, int g, int i, int v);
    check({name, "_grant"}, int'(grant), g);
    check({name, "_idx"}, int'(grant_idx), i);
    check({name, "_valid"}, int'(grant_valid), v);
  endtask

  initial begin
    run = 1'b1;
    step(2);
    expect_out("reset", 0, 0, 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    req    = 4'b0100;
    step(1);
    for (int k = 0; k < 12; k++) begin
      expect_out("single", 4, 2, 1);
      step(1);
    end

    #1 rst_n = 1'b0;
    #1 expect_out("async_rst", 0, 0, 0);
    req = '0;
    step(1);
    rst_n = 1'b1;
    step(2);
    expect_out("post_rst_idle", 0, 0, 0);

    req = 4'b1111;
    step(1);
    for (int k = 0; k < 20; k++) begin
      expect_out("contend", 1 << ((k / 4) % 4), (k / 4) % 4, 1);
      step(1);
    end

    reset_sync();
    req = 4'b0010;
    step(1);
    expect_out("early_a", 2, 1, 1);
    req = 4'b1010;
    step(1);
    expect_out("early_b", 2, 1, 1);
    req = 4'b1000;
    step(1);
    expect_out("early_hand", 8, 3, 1);

    reset_sync();
    req = 4'b0100;
    step(1);
    expect_out("wrap_a", 4, 2, 1);
    req = 4'b0011;
    step(1);
    expect_out("wrap_b", 1, 0, 1);
    step(3);
    expect_out("wrap_hold", 1, 0, 1);
    step(1);
    expect_out("wrap_ptr", 2, 1, 1);

    reset_sync();
    req = 4'b0100;
    step(1);
    expect_out("en_a", 4, 2, 1);
    enable = 1'b0;
    step(1);
    expect_out("en_off", 0, 0, 0);
    req = 4'b0101;
    step(1);
    expect_out("en_still_off", 0, 0, 0);
    enable = 1'b1;
    step(1);
    expect_out("en_wrap", 1, 0, 1);

    reset_sync();
    foreach (tbl[i]) begin
      enable = tbl[i].en;
      req    = tbl[i].r;
      step(tbl[i].n);
    end

    @(negedge clk);
    #1 run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
